// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode encodings and width helper for the scan mux
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Index width that never collapses to zero bits, even for tiny counts.
    function automatic int clog2_safe(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// rtl/mod_n_counter.sv - modulo-N up counter with synchronous clear
module mod_n_counter
    import mux_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      inc,
    output logic [clog2_safe(N)-1:0]  count,
    output logic                      last
);

    localparam int W = clog2_safe(N);

    assign last = (count == W'(N - 1));

    // Advance on inc and fold back to 0 after N-1 so count never reaches N; clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/mux_n_1_scan.sv
// rtl/mux_n_1_scan.sv - N-to-1 channel mux with direct/scan select and registered handshake output
module mux_n_1_scan
    import mux_pkg::*;
#(
    parameter  int N_CH   = 8,
    parameter  int DATA_W = 1,
    localparam int SEL_W  = clog2_safe(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_CH*DATA_W-1:0]   din,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        dout,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     wrap
);

    logic              scan_mode;
    logic              capture;
    logic              scan_last;
    logic [SEL_W-1:0]  scan_count;
    logic [SEL_W-1:0]  ch_idx;
    logic [DATA_W-1:0] ch_data;

    assign scan_mode = (mode == MODE_SCAN);

    // A new sample is taken whenever requested and the output slot is free or being drained.
    assign capture = en && (!out_valid || out_ready);

    // Held at channel 0 whenever DIRECT mode is selected so every scan sweep starts fresh.
    mod_n_counter #(
        .N (N_CH)
    ) u_scan_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!scan_mode),
        .inc   (capture && scan_mode),
        .count (scan_count),
        .last  (scan_last)
    );

    // Pick the channel index and its data; indices past the last channel read as zero.
    always_comb begin
        ch_idx  = scan_mode ? scan_count : sel;
        ch_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_idx == SEL_W'(k)) begin
                ch_data = din[k*DATA_W +: DATA_W];
            end
        end
    end

    // Output register: load on capture, drop valid once accepted, hold everything on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            out_ch    <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= capture && scan_mode && scan_last;
            if (capture) begin
                out_valid <= 1'b1;
                dout      <= ch_data;
                out_ch    <= ch_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
